mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the single unified memory port between instruction fetch (IF, read-only) and the LSU (read/write).
- Transactions are serialized, one outstanding at a time.
- Each requester gets a VALID/READY handshake: the requester holds VALID until READY, so the pipeline hazard controller's `VALID & ~READY` stall works unchanged.
- Sits between the IF/MEM stages and the memory bus interface.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobes are DATA_W/8 bits
- LSU_STREAK_MAX, 4, max consecutive LSU grants while IF waits (1..15)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_if_VALID  in  1  IF read request, held until o_if_READY
- i_if_addr  in  ADDR_W  IF read address
- o_if_READY  out  1  one-cycle completion pulse for IF
- o_if_rdata  out  DATA_W  fetch data, valid while o_if_READY=1
- i_lsu_VALID  in  1  LSU request, held until o_lsu_READY
- i_lsu_we  in  1  1=write, 0=read
- i_lsu_addr  in  ADDR_W  LSU address
- i_lsu_wdata  in  DATA_W  write data
- i_lsu_wstrb  in  DATA_W/8  write byte strobes
- o_lsu_READY  out  1  one-cycle completion pulse for LSU
- o_lsu_rdata  out  DATA_W  load data, valid while o_lsu_READY=1
- o_mem_req  out  1  memory request
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_wstrb  out  DATA_W/8  memory byte strobes; forced 0 for reads
- i_mem_gnt  in  1  request accepted this cycle when o_mem_req=1
- i_mem_rvalid  in  1  response (read data or write ack), >=1 cycle after gnt
- i_mem_rdata  in  DATA_W  read data, qualified by i_mem_rvalid

## Operation
FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE:** if any VALID, pick owner, latch that requester's addr/we/wdata/wstrb into internal registers, go to REQ. No VALID: stay.
  - IF requests latch we=0 and wstrb=0.
- **REQ:** o_mem_req=1; o_mem_* driven from the latched registers, stable until gnt. On i_mem_gnt go to WAIT, else stay.
- **WAIT:** o_mem_req=0. On i_mem_rvalid, register i_mem_rdata into the owner's rdata register and go to RESP.
- **RESP:** owner's READY=1 for exactly this cycle, then IDLE.
  - The other READY stays 0.
  - VALID inputs are ignored in RESP.

Arbitration in IDLE:
- Only one VALID: that requester wins.
- Both VALID: LSU wins unless streak == LSU_STREAK_MAX, in which case IF wins.

Streak counter, 4 bits, updated only at grant:
- LSU granted while i_if_VALID=1: +1, saturating at LSU_STREAK_MAX.
- IF granted, or LSU granted with i_if_VALID=0: cleared to 0.

Other rules:
- i_mem_gnt outside REQ is ignored.
- i_mem_rvalid outside WAIT is ignored; no state change.
- Requests are never dropped or reordered. A request that loses arbitration is re-evaluated in the next IDLE.
- o_if_rdata and o_lsu_rdata hold their last captured value; they are 0 after reset.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release):
  - FSM=IDLE, streak=0, latched fields=0.
  - All outputs 0: READYs, rdata, and all o_mem_*.
- Reset mid-transaction aborts it. No READY is issued, and any late i_mem_rvalid is ignored because the FSM is in IDLE.
- Minimum latency, with VALID seen in IDLE at cycle 0 and gnt same-cycle:
  - REQ at cycle 1
  - rvalid at cycle 2 at earliest
  - READY at cycle 3
  - IDLE at cycle 4
- Back-to-back grants are at least 4 cycles apart. Each extra gnt or rvalid wait cycle adds 1.
- READY pulses are registered: asserted from a state, never combinationally from i_mem_*.
- The requester may drop or change VALID in the cycle after READY. That cycle is IDLE, where the new VALID is arbitrated.
- A VALID that rises during REQ/WAIT/RESP is served no earlier than the next IDLE.

## Test plan
- **Single IF read:** addr 0x100, gnt immediate, rvalid 1 cycle after gnt, rdata 0xDEADBEEF.
  - Required: o_mem_req=1 on cycle 1 only, o_mem_we=0, o_mem_wstrb=0.
  - Required: o_if_READY=1 on cycle 3 only, o_if_rdata=0xDEADBEEF, o_lsu_READY never 1.
- **LSU write with bus stall:** addr 0x2000, wdata 0x12345678, wstrb 0b0011, gnt held low 3 cycles.
  - Required: o_mem_* stable for all 4 REQ cycles.
  - Required: o_lsu_READY pulses 1 cycle after rvalid.
- **Simultaneous IF and LSU VALID:** LSU wins; IF completes on the following transaction.
  - Required: IF READY no earlier than 4 cycles after LSU READY.
- **Starvation limit:** IF VALID held while LSU issues 6 back-to-back loads, LSU_STREAK_MAX=4.
  - Required grant order: LSU×4, IF, LSU×2.
  - Required: streak reads 0 after the IF grant.
- **Reset in WAIT:** assert i_rst_n=0 during WAIT, deassert, then inject i_mem_rvalid.
  - Required: no READY, all outputs 0, FSM stays IDLE.
  - Required: a new IF request afterwards completes normally.
- **Spurious responses:** i_mem_rvalid in IDLE/REQ and i_mem_gnt in WAIT.
  - Required: no state change and no READY pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Serializes IF fetches and LSU loads/stores onto one memory port
//            with VALID/READY handshakes and a bounded LSU-priority streak.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LSU_STREAK_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_if_VALID,
  input  logic [ADDR_W-1:0]     i_if_addr,
  output logic                  o_if_READY,
  output logic [DATA_W-1:0]     o_if_rdata,
  input  logic                  i_lsu_VALID,
  input  logic                  i_lsu_we,
  input  logic [ADDR_W-1:0]     i_lsu_addr,
  input  logic [DATA_W-1:0]     i_lsu_wdata,
  input  logic [DATA_W/8-1:0]   i_lsu_wstrb,
  output logic                  o_lsu_READY,
  output logic [DATA_W-1:0]     o_lsu_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wstrb,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int         c_STRB_W     = DATA_W / 8;
  localparam logic [3:0] c_STREAK_MAX = 4'(LSU_STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_owner_lsu;
  logic                  r_mem_req;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_STRB_W-1:0]   r_wstrb;
  logic [3:0]            r_streak;
  logic                  r_if_ready;
  logic                  r_lsu_ready;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_lsu_rdata;

  logic                  w_any_valid;
  logic                  w_grant_lsu;

  assign w_any_valid = i_if_VALID | i_lsu_VALID;
  // LSU has priority until it has starved a waiting IF for the full streak
  assign w_grant_lsu = i_lsu_VALID & (~i_if_VALID | (r_streak != c_STREAK_MAX));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_owner_lsu <= 1'b0;
      r_mem_req   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_streak    <= '0;
      r_if_ready  <= 1'b0;
      r_lsu_ready <= 1'b0;
      r_if_rdata  <= '0;
      r_lsu_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_state     <= REQ;
            r_mem_req   <= 1'b1;
            r_owner_lsu <= w_grant_lsu;
            if (w_grant_lsu) begin
              r_addr  <= i_lsu_addr;
              r_we    <= i_lsu_we;
              r_wdata <= i_lsu_wdata;
              r_wstrb <= i_lsu_we ? i_lsu_wstrb : '0;
              if (i_if_VALID)
                r_streak <= (r_streak >= c_STREAK_MAX) ? c_STREAK_MAX : r_streak + 4'd1;
              else
                r_streak <= '0;
            end else begin
              r_addr   <= i_if_addr;
              r_we     <= 1'b0;
              r_wdata  <= '0;
              r_wstrb  <= '0;
              r_streak <= '0;
            end
          end
        end
        REQ: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            r_state <= RESP;
            if (r_owner_lsu) begin
              r_lsu_rdata <= i_mem_rdata;
              r_lsu_ready <= 1'b1;
            end else begin
              r_if_rdata <= i_mem_rdata;
              r_if_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          r_if_ready  <= 1'b0;
          r_lsu_ready <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_if_READY  = r_if_ready;
  assign o_if_rdata  = r_if_rdata;
  assign o_lsu_READY = r_lsu_ready;
  assign o_lsu_rdata = r_lsu_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed vector table plus hand sequences for mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam logic        T    = 1'b1;
  localparam logic        F    = 1'b0;
  localparam logic [31:0] Z32  = 32'h0;
  localparam logic [3:0]  Z4   = 4'h0;
  localparam logic [31:0] MASK = 32'hA5A5_0000;
  localparam logic [31:0] IF_A = 32'h3000_0000;
  localparam logic [31:0] LS_A = 32'h4000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_if_VALID;
  logic [31:0] i_if_addr;
  logic        o_if_READY;
  logic [31:0] o_if_rdata;
  logic        i_lsu_VALID;
  logic        i_lsu_we;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_wstrb;
  logic        o_lsu_READY;
  logic [31:0] o_lsu_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_STREAK_MAX(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_VALID(i_if_VALID), .i_if_addr(i_if_addr),
    .o_if_READY(o_if_READY), .o_if_rdata(o_if_rdata),
    .i_lsu_VALID(i_lsu_VALID), .i_lsu_we(i_lsu_we), .i_lsu_addr(i_lsu_addr),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_wstrb(i_lsu_wstrb),
    .o_lsu_READY(o_lsu_READY), .o_lsu_rdata(o_lsu_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct {
    logic        if_v;   logic [31:0] if_a;
    logic        lsu_v;  logic        lsu_we; logic [31:0] lsu_a; logic [31:0] lsu_wd; logic [3:0] lsu_ws;
    logic        gnt;    logic        rv;     logic [31:0] rd;
    logic        e_if_rdy; logic e_lsu_rdy; logic e_req; logic [31:0] e_if_rd; logic [31:0] e_lsu_rd;
    logic [1:0]  chk;    logic        e_we;   logic [31:0] e_addr; logic [31:0] e_wd; logic [3:0] e_ws;
  } vec_t;

  vec_t        tbl [0:23];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_d = '0;
  logic [31:0] grants [$];
  int          first_lsu_cyc, if_cyc;
  logic [3:0]  if_grant_streak;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {24'h0, o_if_READY, o_lsu_READY, o_mem_req, o_mem_we, o_mem_addr,
            o_mem_wdata, o_mem_wstrb, o_if_rdata, o_lsu_rdata};
  endfunction

  // Memory model: grants any request at once, answers one cycle after grant
  task automatic mem_auto();
    i_mem_gnt    = o_mem_req;
    i_mem_rvalid = pend;
    i_mem_rdata  = pend ? pend_d : 32'h0;
    pend = 1'b0;
    if (o_mem_req) begin
      pend   = 1'b1;
      pend_d = o_mem_addr ^ MASK;
    end
  endtask

  // IF holds one fetch while the LSU issues n_lsu back-to-back loads
  task automatic run_seq(input int n_lsu);
    int lsu_done = 0;
    bit if_done = 0, chg_lsu = 0, drop_if = 0, fin = 0;
    grants.delete();
    first_lsu_cyc = -1; if_cyc = -1; if_grant_streak = 4'hF;
    i_if_VALID = 1'b1; i_if_addr = IF_A;
    i_lsu_VALID = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = LS_A;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge i_clk); cyc++;
      if (chg_lsu) begin
        chg_lsu = 0;
        if (lsu_done < n_lsu) i_lsu_addr = LS_A + 32'(4 * lsu_done);
        else i_lsu_VALID = 1'b0;
      end
      if (drop_if) begin drop_if = 0; i_if_VALID = 1'b0; end
      if (if_done && lsu_done == n_lsu && !i_if_VALID && !i_lsu_VALID) begin
        fin = 1;
      end else begin
        mem_auto();
        #1;
        if (o_mem_req && i_mem_gnt) begin
          grants.push_back(o_mem_addr);
          if (o_mem_addr == IF_A) if_grant_streak = dut.r_streak;
        end
        if (o_if_READY && o_lsu_READY) check("both ready", 2'b11, 2'b00);
        if (o_lsu_READY) begin
          check($sformatf("seq lsu rdata %0d", lsu_done), o_lsu_rdata,
                (LS_A + 32'(4 * lsu_done)) ^ MASK);
          lsu_done++; chg_lsu = 1;
          if (first_lsu_cyc < 0) first_lsu_cyc = cyc;
        end
        if (o_if_READY) begin
          check("seq if rdata", o_if_rdata, IF_A ^ MASK);
          if_done = 1; drop_if = 1; if_cyc = cyc;
        end
      end
    end
    check("seq completion", {31'h0, fin}, 32'h1);
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; pend = 1'b0;
  endtask

  initial begin
    logic [31:0] A, A4, D, LA, WD, R55, BAD, R2;
    logic [3:0]  WS;
    logic [31:0] exp_g [7];
    bit          got;
    A = 32'h100; A4 = 32'h104; D = 32'hDEADBEEF; LA = 32'h2000; WD = 32'h12345678;
    WS = 4'b0011; R55 = 32'h55; BAD = 32'hBAD; R2 = 32'h11112222;

    // order: if_v,if_a, lsu_v,we,a,wd,ws, gnt,rv,rd, e_if_rdy,e_lsu_rdy,e_req,e_if_rd,e_lsu_rd, chk,e_we,e_addr,e_wd,e_ws
    tbl[0]  = '{T,A,   F,F,Z32,Z32,Z4, F,F,Z32, F,F,F,Z32,Z32, 2'd0,F,Z32,Z32,Z4};
    tbl[1]  = '{T,A,   F,F,Z32,Z32,Z4, T,F,Z32, F,F,T,Z32,Z32, 2'd1,F,A,Z32,Z4};
    tbl[2]  = '{T,A,   F,F,Z32,Z32,Z4, F,T,D,   F,F,F,Z32,Z32, 2'd0,F,Z32,Z32,Z4};
    tbl[3]  = '{T,A,   F,F,Z32,Z32,Z4, F,F,Z32, T,F,F,D,Z32,   2'd0,F,Z32,Z32,Z4};
    tbl[4]  = '{F,Z32, F,F,Z32,Z32,Z4, F,F,Z32, F,F,F,D,Z32,   2'd0,F,Z32,Z32,Z4};
    tbl[5]  = '{F,Z32, T,T,LA,WD,WS,   F,F,Z32, F,F,F,D,Z32,   2'd0,F,Z32,Z32,Z4};
    tbl[6]  = '{F,Z32, T,T,LA,WD,WS,   F,F,Z32, F,F,T,D,Z32,   2'd3,T,LA,WD,WS};
    tbl[7]  = '{F,Z32, T,T,LA,WD,WS,   F,F,Z32, F,F,T,D,Z32,   2'd3,T,LA,WD,WS};
    tbl[8]  = '{F,Z32, T,T,LA,WD,WS,   F,F,Z32, F,F,T,D,Z32,   2'd3,T,LA,WD,WS};
    tbl[9]  = '{F,Z32, T,T,LA,WD,WS,   T,F,Z32, F,F,T,D,Z32,   2'd3,T,LA,WD,WS};
    tbl[10] = '{F,Z32, T,T,LA,WD,WS,   F,F,Z32, F,F,F,D,Z32,   2'd0,F,Z32,Z32,Z4};
    tbl[11] = '{F,Z32, T,T,LA,WD,WS,   F,T,R55, F,F,F,D,Z32,   2'd0,F,Z32,Z32,Z4};
    tbl[12] = '{F,Z32, T,T,LA,WD,WS,   F,F,Z32, F,T,F,D,R55,   2'd0,F,Z32,Z32,Z4};
    tbl[13] = '{F,Z32, F,F,Z32,Z32,Z4, F,F,Z32, F,F,F,D,R55,   2'd0,F,Z32,Z32,Z4};
    tbl[14] = '{F,Z32, F,F,Z32,Z32,Z4, T,T,BAD, F,F,F,D,R55,   2'd0,F,Z32,Z32,Z4};
    tbl[15] = '{F,Z32, F,F,Z32,Z32,Z4, F,F,Z32, F,F,F,D,R55,   2'd0,F,Z32,Z32,Z4};
    tbl[16] = '{T,A4,  F,F,Z32,Z32,Z4, F,F,Z32, F,F,F,D,R55,   2'd0,F,Z32,Z32,Z4};
    tbl[17] = '{T,A4,  F,F,Z32,Z32,Z4, F,T,BAD, F,F,T,D,R55,   2'd1,F,A4,Z32,Z4};
    tbl[18] = '{T,A4,  F,F,Z32,Z32,Z4, T,F,Z32, F,F,T,D,R55,   2'd1,F,A4,Z32,Z4};
    tbl[19] = '{T,A4,  F,F,Z32,Z32,Z4, T,F,Z32, F,F,F,D,R55,   2'd0,F,Z32,Z32,Z4};
    tbl[20] = '{T,A4,  F,F,Z32,Z32,Z4, T,F,Z32, F,F,F,D,R55,   2'd0,F,Z32,Z32,Z4};
    tbl[21] = '{T,A4,  F,F,Z32,Z32,Z4, F,T,R2,  F,F,F,D,R55,   2'd0,F,Z32,Z32,Z4};
    tbl[22] = '{T,A4,  F,F,Z32,Z32,Z4, F,F,Z32, T,F,F,R2,R55,  2'd0,F,Z32,Z32,Z4};
    tbl[23] = '{F,Z32, F,F,Z32,Z32,Z4, F,F,Z32, F,F,F,R2,R55,  2'd0,F,Z32,Z32,Z4};

    i_rst_n = 1'b0; i_if_VALID = 1'b0; i_if_addr = '0; i_lsu_VALID = 1'b0; i_lsu_we = 1'b0;
    i_lsu_addr = '0; i_lsu_wdata = '0; i_lsu_wstrb = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (2) @(negedge i_clk);
    #1;
    check("reset outputs", all_outs(), 160'h0);
    check("reset streak", {28'h0, dut.r_streak}, 32'h0);
    @(negedge i_clk); i_rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge i_clk); cyc++;
      i_if_VALID = tbl[i].if_v; i_if_addr = tbl[i].if_a;
      i_lsu_VALID = tbl[i].lsu_v; i_lsu_we = tbl[i].lsu_we; i_lsu_addr = tbl[i].lsu_a;
      i_lsu_wdata = tbl[i].lsu_wd; i_lsu_wstrb = tbl[i].lsu_ws;
      i_mem_gnt = tbl[i].gnt; i_mem_rvalid = tbl[i].rv; i_mem_rdata = tbl[i].rd;
      #1;
      check($sformatf("row%0d ctl", i),
            {o_if_READY, o_lsu_READY, o_mem_req, o_if_rdata, o_lsu_rdata},
            {tbl[i].e_if_rdy, tbl[i].e_lsu_rdy, tbl[i].e_req, tbl[i].e_if_rd, tbl[i].e_lsu_rd});
      if (tbl[i].chk[0])
        check($sformatf("row%0d bus", i), {o_mem_we, o_mem_addr, o_mem_wstrb},
              {tbl[i].e_we, tbl[i].e_addr, tbl[i].e_ws});
      if (tbl[i].chk[1])
        check($sformatf("row%0d wdata", i), o_mem_wdata, tbl[i].e_wd);
    end
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

    // Simultaneous request: LSU first, IF at least 4 cycles after LSU READY
    run_seq(1);
    check("simul grant count", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) check("simul grant order", {grants[0], grants[1]}, {LS_A, IF_A});
    check("simul ready spacing", {31'h0, (first_lsu_cyc >= 0 && if_cyc - first_lsu_cyc >= 4)}, 32'h1);

    // Starvation limit: LSU x4, IF, LSU x2
    run_seq(6);
    exp_g = '{LS_A, LS_A + 32'd4, LS_A + 32'd8, LS_A + 32'd12, IF_A, LS_A + 32'd16, LS_A + 32'd20};
    check("starve grant count", 32'(grants.size()), 32'd7);
    for (int g = 0; g < 7 && g < grants.size(); g++)
      check($sformatf("starve grant %0d", g), grants[g], exp_g[g]);
    check("starve streak at IF grant", {28'h0, if_grant_streak}, 32'h0);

    // Reset during WAIT, then a late rvalid must be ignored
    @(negedge i_clk); i_if_VALID = 1'b1; i_if_addr = 32'h500;
    @(negedge i_clk); i_mem_gnt = 1'b1; #1;
    check("rst seq req", {31'h0, o_mem_req}, 32'h1);
    @(negedge i_clk); i_mem_gnt = 1'b0; #1;
    check("rst seq wait", {31'h0, o_mem_req}, 32'h0);
    i_rst_n = 1'b0; i_if_VALID = 1'b0; #1;
    check("rst async outputs", all_outs(), 160'h0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(negedge i_clk); i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBADBAD;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk); i_mem_rvalid = 1'b0; i_mem_rdata = '0; #1;
      check($sformatf("post-rst outputs %0d", k), all_outs(), 160'h0);
      check($sformatf("post-rst state %0d", k), 32'(int'(dut.r_state)), 32'h0);
    end

    i_if_VALID = 1'b1; i_if_addr = 32'h600; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge i_clk); cyc++;
      mem_auto(); #1;
      if (o_lsu_READY) check("post-rst lsu ready", 1'b1, 1'b0);
      if (o_if_READY) begin
        got = 1;
        check("post-rst if rdata", o_if_rdata, 32'h600 ^ MASK);
      end
    end
    check("post-rst if done", {31'h0, got}, 32'h1);
    @(negedge i_clk); i_if_VALID = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    repeat (2) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
